// File: rtl/q_action_selector.sv
// q_action_selector
// Consumes the feed-forward engine's result stream and picks an action from
// the output-layer Q-values. The block has three phases:
//   COLLECT - store output-layer beats (layer code 2'b11) by node address
//   SELECT  - linear arg-max scan, one FP32 comparison per cycle
//   DECIDE  - choose the greedy index, or an LFSR-driven random index when
//             epsilon-greedy exploration fires, and publish the result
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_current_layer   layer code from the engine (2'b11 output, 2'b00 input)
//   i_data_valid      result beat valid
//   i_data_addr       node index of the beat
//   i_data            FP32 Q-value
//   i_explore_en      enable epsilon-greedy exploration
//   i_epsilon         exploration threshold (explore when lfsr <= i_epsilon)
//   o_action          selected action index
//   o_q_max           greedy maximum Q-value (reported even when exploring)
//   o_explored        o_action came from the LFSR
//   o_valid           one-cycle pulse when the outputs above change
//   o_busy            high while in SELECT or DECIDE
module q_action_selector #(
  parameter int              DATA_WIDTH            = 32,
  parameter int              NUMBER_OF_OUTPUT_NODE = 3,
  parameter int              ADDR_WIDTH            = 5,
  parameter int              ACTION_WIDTH          = 2,
  parameter logic [15:0]     LFSR_SEED             = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              i_current_layer,
  input  logic                    i_data_valid,
  input  logic [ADDR_WIDTH-1:0]   i_data_addr,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_explore_en,
  input  logic [15:0]             i_epsilon,
  output logic [ACTION_WIDTH-1:0] o_action,
  output logic [DATA_WIDTH-1:0]   o_q_max,
  output logic                    o_explored,
  output logic                    o_valid,
  output logic                    o_busy
);

  localparam int N      = NUMBER_OF_OUTPUT_NODE;
  localparam int LAST   = N - 1;
  localparam int CNT_W  = $clog2(N + 1);

  localparam logic [CNT_W-1:0]        LAST_CNT = LAST[CNT_W-1:0];
  localparam logic [ACTION_WIDTH-1:0] LAST_IDX = LAST[ACTION_WIDTH-1:0];
  localparam logic [ACTION_WIDTH:0]   N_EXT    = N[ACTION_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0]   N_ADDR   = N[ADDR_WIDTH-1:0];

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_SELECT  = 2'd1,
    S_DECIDE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0]   q_buf [N];
  logic [CNT_W-1:0]        count;
  logic [ACTION_WIDTH-1:0] best_idx;
  logic [ACTION_WIDTH-1:0] cmp_idx;
  logic [DATA_WIDTH-1:0]   best_val;
  logic [15:0]             lfsr;
  logic [15:0]             lfsr_next;

  logic                    accept;
  logic                    last_beat;
  logic                    abort;
  logic                    last_cmp;
  logic [ACTION_WIDTH-1:0] addr_idx;
  logic [DATA_WIDTH-1:0]   cmp_val;
  logic                    explore;
  logic [ACTION_WIDTH-1:0] rand_action;

  // Sign-magnitude ordering of FP32 values. +0 and -0 compare equal;
  // NaN and Inf fall out of the raw-bit ordering without special handling.
  function automatic logic fp_gt(input logic [DATA_WIDTH-1:0] a,
                                 input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-2:0] mag_a, mag_b;
    mag_a = a[DATA_WIDTH-2:0];
    mag_b = b[DATA_WIDTH-2:0];
    if (mag_a == '0 && mag_b == '0)
      return 1'b0;
    else if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
      return ~a[DATA_WIDTH-1];
    else if (!a[DATA_WIDTH-1])
      return mag_a > mag_b;
    else
      return mag_a < mag_b;
  endfunction

  // Address is range-checked before use, so the low bits are a valid index.
  assign addr_idx  = i_data_addr[ACTION_WIDTH-1:0];
  assign accept    = (state == S_COLLECT) && i_data_valid &&
                     (i_current_layer == 2'b11) && (i_data_addr < N_ADDR);
  assign last_beat = accept && (count == LAST_CNT);
  // A new inference starting (input layer) invalidates a half-filled set.
  assign abort     = (state == S_COLLECT) && (i_current_layer == 2'b00) &&
                     (count != '0);
  assign last_cmp  = (cmp_idx == LAST_IDX);
  assign cmp_val   = q_buf[cmp_idx];
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  assign explore   = i_explore_en && (lfsr <= i_epsilon);

  // Fold the raw LFSR bits into 0..N-1 with a single conditional subtract.
  always_comb begin
    logic [ACTION_WIDTH:0] r_ext;
    // NOTE: every variable written here gets a value before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    r_ext = {1'b0, lfsr[ACTION_WIDTH-1:0]};
    if (r_ext >= N_EXT)
      r_ext = r_ext - N_EXT;
    rand_action = r_ext[ACTION_WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_COLLECT;
    else
      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_COLLECT: if (last_beat) state_next = S_SELECT;
      S_SELECT:  if (last_cmp)  state_next = S_DECIDE;
      S_DECIDE:                 state_next = S_COLLECT;
      default:                  state_next = S_COLLECT;
    endcase
  end

  // Output decode.
  always_comb begin
    o_busy = (state == S_SELECT) || (state == S_DECIDE);
  end

  // Datapath: capture buffer, arg-max scan, decision registers and LFSR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the capture buffer is reset as well, so a stale Q-value from an
      // interrupted inference can never surface as a result after reset.
      for (int i = 0; i < N; i++)
        q_buf[i] <= '0;
      count      <= '0;
      best_idx   <= '0;
      cmp_idx    <= '0;
      best_val   <= '0;
      lfsr       <= LFSR_SEED;
      o_action   <= '0;
      o_q_max    <= '0;
      o_explored <= 1'b0;
      o_valid    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // reads the value from before this edge regardless of statement order.
      lfsr    <= lfsr_next;
      o_valid <= 1'b0;
      case (state)
        S_COLLECT: begin
          if (accept) begin
            q_buf[addr_idx] <= i_data;
            count           <= count + 1'b1;
            if (last_beat) begin
              // Seed the scan with entry 0; the buffer write for this beat
              // is not visible yet, so forward it when it targets entry 0.
              best_idx <= '0;
              best_val <= (addr_idx == '0) ? i_data : q_buf[0];
              cmp_idx  <= {{(ACTION_WIDTH-1){1'b0}}, 1'b1};
            end
          end else if (abort) begin
            count <= '0;
          end
        end
        S_SELECT: begin
          // Strict compare: ties keep the lower index.
          if (fp_gt(cmp_val, best_val)) begin
            best_idx <= cmp_idx;
            best_val <= cmp_val;
          end
          cmp_idx <= cmp_idx + 1'b1;
        end
        S_DECIDE: begin
          o_action   <= explore ? rand_action : best_idx;
          o_q_max    <= best_val;
          o_explored <= explore;
          o_valid    <= 1'b1;
          count      <= '0;
        end
        default: count <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_q_action_selector.sv
// Self-checking bench for q_action_selector (default parameters, N=3).
// Stimulus tasks push expected decisions into a scoreboard queue; a monitor
// on the falling edge pops and compares whenever o_valid is seen. The LFSR
// model below tracks the sequence the DUT must follow from reset so that
// exploration outcomes can be predicted exactly.
module tb_q_action_selector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  i_current_layer;
  logic        i_data_valid;
  logic [4:0]  i_data_addr;
  logic [31:0] i_data;
  logic        i_explore_en;
  logic [15:0] i_epsilon;
  logic [1:0]  o_action;
  logic [31:0] o_q_max;
  logic        o_explored;
  logic        o_valid;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;

  q_action_selector dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_current_layer (i_current_layer),
    .i_data_valid    (i_data_valid),
    .i_data_addr     (i_data_addr),
    .i_data          (i_data),
    .i_explore_en    (i_explore_en),
    .i_epsilon       (i_epsilon),
    .o_action        (o_action),
    .o_q_max         (o_q_max),
    .o_explored      (o_explored),
    .o_valid         (o_valid),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  action;
    logic [31:0] q_max;
    logic        explore_en;
    logic [15:0] epsilon;
  } exp_t;

  typedef struct {
    logic [31:0] q0;
    logic [31:0] q1;
    logic [31:0] q2;
    logic [1:0]  action;
    logic [31:0] q_max;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference LFSR: x^16+x^14+x^13+x^11+1 Galois, seed ACE1, steps every edge.
  logic [15:0] m_lfsr, m_lfsr_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr      <= 16'hACE1;
      m_lfsr_prev <= 16'hACE1;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
  end

  // Monitor: m_lfsr_prev holds the LFSR value seen at the DECIDE edge.
  logic       prev_valid = 1'b0;
  exp_t       mon_e;
  logic       mon_explore;
  logic [1:0] mon_action;
  logic [2:0] mon_r;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (o_valid) begin
        check("valid_single_pulse", {31'd0, prev_valid}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got o_valid=1 expected no result at %0t", $time);
        end else begin
          mon_e       = sb.pop_front();
          mon_explore = mon_e.explore_en && (m_lfsr_prev <= mon_e.epsilon);
          mon_r       = {1'b0, m_lfsr_prev[1:0]};
          if (mon_r >= 3'd3) mon_r = mon_r - 3'd3;
          mon_action  = mon_explore ? mon_r[1:0] : mon_e.action;
          check("o_action",   {30'd0, o_action},   {30'd0, mon_action});
          check("o_q_max",    o_q_max,             mon_e.q_max);
          check("o_explored", {31'd0, o_explored}, {31'd0, mon_explore});
          check("action_range", {31'd0, (o_action < 2'd3)}, 32'd1);
        end
      end
      prev_valid = o_valid;
    end
  end

  task automatic beat(input logic [1:0] layer, input logic [4:0] addr,
                      input logic [31:0] d);
    i_current_layer = layer;
    i_data_addr     = addr;
    i_data          = d;
    i_data_valid    = 1'b1;
    @(posedge clk);
    #1;
    i_data_valid    = 1'b0;
    i_current_layer = 2'b10;
  endtask

  task automatic push_exp(input logic [1:0] act, input logic [31:0] qm);
    exp_t e;
    e.action     = act;
    e.q_max      = qm;
    e.explore_en = i_explore_en;
    e.epsilon    = i_epsilon;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL result_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_set(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [1:0] act,
                          input logic [31:0] qm);
    push_exp(act, qm);
    beat(2'b11, 5'd0, a);
    beat(2'b11, 5'd1, b);
    beat(2'b11, 5'd2, c);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int busy_cnt;

    vecs[0] = '{32'h3F800000, 32'h40200000, 32'h3F000000, 2'd1, 32'h40200000};
    vecs[1] = '{32'hBF800000, 32'hC0400000, 32'hBF000000, 2'd2, 32'hBF000000};
    vecs[2] = '{32'h3F800000, 32'h3F800000, 32'h3F000000, 2'd0, 32'h3F800000};
    vecs[3] = '{32'h80000000, 32'h00000000, 32'hBF800000, 2'd0, 32'h80000000};
    vecs[4] = '{32'h40000000, 32'h40000000, 32'h40000000, 2'd0, 32'h40000000};
    vecs[5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 2'd2, 32'h40400000};
    vecs[6] = '{32'hBF800000, 32'h00000000, 32'h80000000, 2'd1, 32'h00000000};
    vecs[7] = '{32'hC2C80000, 32'h3DCCCCCD, 32'h42C80000, 2'd2, 32'h42C80000};

    i_current_layer = 2'b10;
    i_data_valid    = 1'b0;
    i_data_addr     = '0;
    i_data          = '0;
    i_explore_en    = 1'b0;
    i_epsilon       = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_action",   {30'd0, o_action},   32'd0);
    check("rst_o_q_max",    o_q_max,             32'd0);
    check("rst_o_explored", {31'd0, o_explored}, 32'd0);
    check("rst_o_valid",    {31'd0, o_valid},    32'd0);
    check("rst_o_busy",     {31'd0, o_busy},     32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Greedy positive set with latency and busy-duration measurement.
    push_exp(2'd1, 32'h40200000);
    beat(2'b11, 5'd0, 32'h3F800000);
    beat(2'b11, 5'd1, 32'h40200000);
    beat(2'b11, 5'd2, 32'h3F000000);
    check("busy_after_last_beat", {31'd0, o_busy}, 32'd1);
    lat      = 0;
    busy_cnt = 1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (o_busy) busy_cnt++;
      if (o_valid && lat == 0) lat = k + 1;
      if (!o_busy && lat != 0) break;
    end
    check("valid_latency_edges", lat, 32'd4);
    check("busy_cycles", busy_cnt, 32'd3);
    wait_idle();

    // Table-driven greedy vectors.
    for (int v = 0; v < 8; v++)
      send_set(vecs[v].q0, vecs[v].q1, vecs[v].q2, vecs[v].action, vecs[v].q_max);

    // Out-of-order addresses with stray beats that must be ignored.
    push_exp(2'd2, 32'h40A00000);
    beat(2'b11, 5'd2,  32'h40A00000);
    beat(2'b11, 5'd3,  32'h41200000);
    beat(2'b11, 5'd0,  32'h3F800000);
    beat(2'b10, 5'd1,  32'h41200000);
    beat(2'b11, 5'd31, 32'h41200000);
    beat(2'b11, 5'd1,  32'h40000000);
    wait_idle();
    repeat (6) @(posedge clk);
    #1;

    // Partial set aborted by an input-layer cycle, then a fresh set.
    beat(2'b11, 5'd0, 32'h41200000);
    beat(2'b11, 5'd1, 32'h41200000);
    i_current_layer = 2'b00;
    @(posedge clk);
    #1;
    i_current_layer = 2'b10;
    send_set(32'h3F800000, 32'h3F000000, 32'h40000000, 2'd2, 32'h40000000);

    // Reset asserted during SELECT: outputs clear, no result follows.
    beat(2'b11, 5'd0, 32'h3F800000);
    beat(2'b11, 5'd1, 32'h40200000);
    beat(2'b11, 5'd2, 32'h3F000000);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_o_action",   {30'd0, o_action},   32'd0);
    check("midrst_o_q_max",    o_q_max,             32'd0);
    check("midrst_o_explored", {31'd0, o_explored}, 32'd0);
    check("midrst_o_valid",    {31'd0, o_valid},    32'd0);
    check("midrst_o_busy",     {31'd0, o_busy},     32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send_set(32'hBF800000, 32'hC0400000, 32'hBF000000, 2'd2, 32'hBF000000);

    // Exploration always on.
    i_explore_en = 1'b1;
    i_epsilon    = 16'hFFFF;
    for (int n = 0; n < 50; n++)
      send_set(32'h3F800000, 32'h40200000, 32'h3F000000, 2'd1, 32'h40200000);

    // Exploration enabled but epsilon zero: never explores.
    i_epsilon = 16'h0000;
    for (int n = 0; n < 10; n++)
      send_set(32'h3F800000, 32'h40200000, 32'h3F000000, 2'd1, 32'h40200000);

    // Mid-range epsilon: outcome follows the LFSR value at decision time.
    i_epsilon = 16'h8000;
    for (int n = 0; n < 20; n++)
      send_set(32'hBF800000, 32'h00000000, 32'h80000000, 2'd1, 32'h00000000);

    i_explore_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/q_action_selector.md
Name: q_action_selector

Overview:
- Downstream consumer of the feed-forward engine's result stream.
- Captures the Q-values produced while the engine reports the output layer (layer code 2'b11), keyed by node address.
- Finds the index of the largest IEEE-754 single-precision Q-value (greedy action).
- Optionally replaces that index with a pseudo-random action (epsilon-greedy). Presents the chosen action and max Q to the agent/controller with a one-cycle valid pulse.

Parameters:
- DATA_WIDTH, 32, Q-value width (IEEE-754 single; only 32 supported).
- NUMBER_OF_OUTPUT_NODE, 3, number of actions/Q-values per inference (2..2^ACTION_WIDTH).
- ADDR_WIDTH, 5, width of incoming node address (matches the engine's address bus).
- ACTION_WIDTH, 2, width of action index.
- LFSR_SEED, 16'hACE1, LFSR reset value (must be non-zero).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- i_current_layer  in  2  layer code from engine; 2'b11 = output layer, 2'b00 = input layer
- i_data_valid  in  1  result beat valid
- i_data_addr  in  ADDR_WIDTH  node index of beat
- i_data  in  DATA_WIDTH  Q-value (FP32)
- i_explore_en  in  1  enable epsilon-greedy exploration
- i_epsilon  in  16  exploration threshold (unsigned)
- o_action  out  ACTION_WIDTH  selected action index
- o_q_max  out  DATA_WIDTH  largest captured Q-value (always greedy max, even when exploring)
- o_explored  out  1  1 = o_action is random
- o_valid  out  1  one-cycle pulse: outputs updated
- o_busy  out  1  high in SELECT and DECIDE

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk.
  - Reset values: all outputs 0, state COLLECT, capture count 0, buffer cleared, LFSR = LFSR_SEED.
  - Reset applies at any point, including mid-SELECT or mid-DECIDE; no partial result is emitted afterwards.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every clock in all states; never 0.
- State COLLECT:
  - A beat is accepted when i_data_valid=1, i_current_layer=2'b11 and i_data_addr < NUMBER_OF_OUTPUT_NODE.
  - On acceptance: buf[addr] <= i_data; count increments.
  - Beats with addr >= NUMBER_OF_OUTPUT_NODE, or with any other layer code, are ignored and not counted.
  - A duplicate address overwrites the buffer entry and still counts.
  - The edge that accepts beat number NUMBER_OF_OUTPUT_NODE moves to SELECT, with best_idx=0, best_val=buf[0] (or the incoming data if addr 0 is that beat), and cmp_idx=1.
  - If i_current_layer==2'b00 while 0 < count < NUMBER_OF_OUTPUT_NODE, the partial set is discarded (count <= 0).
- State SELECT: one comparison per cycle, NUMBER_OF_OUTPUT_NODE-1 cycles.
  - If buf[cmp_idx] > best_val (strict), then best_idx <= cmp_idx and best_val <= buf[cmp_idx]. Ties keep the lower index.
  - After the last index, go to DECIDE.
  - i_data_valid is ignored in SELECT and DECIDE.
- FP32 greater-than, combinational, sign-magnitude:
  - Both magnitudes zero (+0/-0): equal.
  - Signs differ: the positive value is greater.
  - Both positive: larger {exp,mant} is greater.
  - Both negative: smaller {exp,mant} is greater.
  - NaN/Inf are not special-cased (handled as raw bits).
- State DECIDE (1 cycle): explore = i_explore_en && (lfsr <= i_epsilon).
  - If explore: r = lfsr[ACTION_WIDTH-1:0]; if r >= NUMBER_OF_OUTPUT_NODE then r = r - NUMBER_OF_OUTPUT_NODE. o_action <= r.
  - Otherwise: o_action <= best_idx.
  - Also registered: o_q_max <= best_val, o_explored <= explore, o_valid <= 1. Then go to COLLECT with count 0.
- Outputs:
  - o_valid is high for exactly one cycle.
  - o_action, o_q_max and o_explored hold until the next decision.
- Latency: o_valid is high after NUMBER_OF_OUTPUT_NODE+1 clock edges counted from the edge that accepts the final beat (4 edges for N=3).
- Epsilon extremes: i_epsilon=0 never explores (LFSR never 0); i_epsilon=16'hFFFF always explores when enabled.

Test Plan:
- Greedy, positive values: explore off; addr0=3F800000 (1.0), addr1=40200000 (2.5), addr2=3F000000 (0.5) -> o_action=1, o_q_max=40200000, o_explored=0, o_valid pulse 4 edges after the addr2 beat, o_busy high 3 cycles.
- Negative values and ties:
  - [BF800000 (-1.0), C0400000 (-3.0), BF000000 (-0.5)] -> o_action=2, o_q_max=BF000000.
  - [3F800000, 3F800000, 3F000000] -> o_action=0.
  - [80000000, 00000000, BF800000] -> o_action=0, o_q_max=80000000.
- Address handling: beats in order addr2, addr0, addr1, plus addr3 and one beat with layer=2'b10 -> the stray beats are ignored, the decision follows the 3 valid beats, and o_valid pulses exactly once.
- Exploration:
  - i_explore_en=1, i_epsilon=FFFF, 50 inferences -> o_explored=1 every time, o_action always in 0..2, o_q_max still the greedy max.
  - i_epsilon=0000 -> o_explored=0 every time.
- Abort and reset:
  - 2 beats, then layer=2'b00, then a full 3-beat set -> a single decision based only on the new set.
  - rst_n asserted during SELECT -> all outputs 0, no o_valid, next full set processed normally.
